// File: rtl/ysyx_22041071_lsu.sv
// MEM stage: one load/store at a time on a variable-latency 64-bit data port,
// with a single-entry result buffer toward WB.
module ysyx_22041071_lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid5,
  output logic        ready5,
  input  logic [63:0] PC5,
  input  logic [31:0] Ins4,
  input  logic        reg_w_en3,
  input  logic [4:0]  rdest2,
  input  logic [63:0] ALU_res,
  input  logic [63:0] st_data,
  input  logic [4:0]  mem_op,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rdata,
  output logic        valid6,
  input  logic        ready6,
  output logic [63:0] PC6,
  output logic [31:0] Ins5,
  output logic        reg_w_en4,
  output logic [4:0]  rdest3,
  output logic [63:0] WB_data1
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t      r_state, w_nxt;
  logic [63:0] r_pc, r_alu, r_wdata;
  logic [31:0] r_ins;
  logic        r_wen;
  logic [4:0]  r_rd;
  logic [3:0]  r_op;
  logic [7:0]  r_wmask;

  logic        r_valid6, r_reg_w_en4;
  logic [63:0] r_pc6, r_wb;
  logic [31:0] r_ins5;
  logic [4:0]  r_rdest3;

  logic        w_acc, w_ld_nm, w_ld_mem;
  logic [7:0]  w_base, w_mask;
  logic [63:0] w_wdata, w_shift, w_load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt         = r_state;
    ready5        = 1'b0;
    mem_req_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready5 = !r_valid6 || ready6;
        if (valid5 && ready5 && mem_op[4]) w_nxt = S_REQ;
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_nxt = S_RESP;
      end
      S_RESP: if (mem_rsp_valid) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  assign w_acc    = valid5 && ready5;
  assign w_ld_nm  = w_acc && !mem_op[4];
  assign w_ld_mem = (r_state == S_RESP) && mem_rsp_valid;

  // Store lane placement; bytes shifted past lane 7 are simply lost.
  always_comb begin
    case (mem_op[2:1])
      2'd0:    w_base = 8'h01;
      2'd1:    w_base = 8'h03;
      2'd2:    w_base = 8'h0F;
      default: w_base = 8'hFF;
    endcase
    w_mask  = w_base << ALU_res[2:0];
    w_wdata = st_data << {ALU_res[2:0], 3'b000};
  end

  always_comb begin
    w_shift = mem_rdata >> {r_alu[2:0], 3'b000};
    case (r_op[2:1])
      2'd0:    w_load = r_op[0] ? {56'd0, w_shift[7:0]}  : {{56{w_shift[7]}},  w_shift[7:0]};
      2'd1:    w_load = r_op[0] ? {48'd0, w_shift[15:0]} : {{48{w_shift[15]}}, w_shift[15:0]};
      2'd2:    w_load = r_op[0] ? {32'd0, w_shift[31:0]} : {{32{w_shift[31]}}, w_shift[31:0]};
      default: w_load = w_shift;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= '0;
      r_ins   <= '0;
      r_wen   <= 1'b0;
      r_rd    <= '0;
      r_op    <= '0;
      r_alu   <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_acc) begin
      r_pc    <= PC5;
      r_ins   <= Ins4;
      r_wen   <= reg_w_en3;
      r_rd    <= rdest2;
      r_op    <= mem_op[3:0];
      r_alu   <= ALU_res;
      r_wdata <= w_wdata;
      r_wmask <= w_mask;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid6    <= 1'b0;
      r_pc6       <= '0;
      r_ins5      <= '0;
      r_reg_w_en4 <= 1'b0;
      r_rdest3    <= '0;
      r_wb        <= '0;
    end else if (w_ld_nm) begin
      r_valid6    <= 1'b1;
      r_pc6       <= PC5;
      r_ins5      <= Ins4;
      r_reg_w_en4 <= reg_w_en3;
      r_rdest3    <= rdest2;
      r_wb        <= ALU_res;
    end else if (w_ld_mem) begin
      r_valid6    <= 1'b1;
      r_pc6       <= r_pc;
      r_ins5      <= r_ins;
      r_reg_w_en4 <= r_wen;
      r_rdest3    <= r_rd;
      r_wb        <= r_op[3] ? r_alu : w_load;
    end else if (ready6) begin
      r_valid6    <= 1'b0;
    end
  end

  assign mem_addr  = {r_alu[63:3], 3'b000};
  assign mem_wen   = r_op[3];
  assign mem_wdata = r_wdata;
  assign mem_wmask = r_wmask;
  assign valid6    = r_valid6;
  assign PC6       = r_pc6;
  assign Ins5      = r_ins5;
  assign reg_w_en4 = r_reg_w_en4;
  assign rdest3    = r_rdest3;
  assign WB_data1  = r_wb;

endmodule

// File: tb/tb_ysyx_22041071_lsu.sv
// Scoreboard bench for the MEM stage: expected WB results are queued at issue
// and retired by a monitor whenever valid6 && ready6.
module tb_ysyx_22041071_lsu;
  logic        clk = 1'b0, reset;
  logic        valid5, ready5, reg_w_en3;
  logic [63:0] PC5, ALU_res, st_data;
  logic [31:0] Ins4;
  logic [4:0]  rdest2, mem_op;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        valid6, ready6, reg_w_en4;
  logic [63:0] PC6, WB_data1;
  logic [31:0] Ins5;
  logic [4:0]  rdest3;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_vec = 0, n_err = 0;

  ysyx_22041071_lsu dut (
    .clk(clk), .reset(reset),
    .valid5(valid5), .ready5(ready5), .PC5(PC5), .Ins4(Ins4), .reg_w_en3(reg_w_en3),
    .rdest2(rdest2), .ALU_res(ALU_res), .st_data(st_data), .mem_op(mem_op),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .valid6(valid6), .ready6(ready6), .PC6(PC6), .Ins5(Ins5), .reg_w_en4(reg_w_en4),
    .rdest3(rdest3), .WB_data1(WB_data1)
  );

  always #5 clk = ~clk;

  // Retire one expected result per WB handshake.
  always @(negedge clk) begin
    if (reset && valid6 && ready6) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL wb_unexpected: got pc=%h data=%h, expected no result", PC6, WB_data1);
      end else begin
        m_e = sb.pop_front();
        if ({PC6, Ins5, reg_w_en4, rdest3, WB_data1} !== {m_e.pc, m_e.ins, m_e.wen, m_e.rd, m_e.data}) begin
          n_err++;
          $display("FAIL wb_result: got pc=%h ins=%h wen=%b rd=%0d data=%h, expected pc=%h ins=%h wen=%b rd=%0d data=%h",
                   PC6, Ins5, reg_w_en4, rdest3, WB_data1, m_e.pc, m_e.ins, m_e.wen, m_e.rd, m_e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_wb(input logic [63:0] pc, input logic [31:0] ins, input logic wen,
                           input logic [4:0] rd, input logic [63:0] data);
    exp_t e;
    e.pc = pc; e.ins = ins; e.wen = wen; e.rd = rd; e.data = data;
    sb.push_back(e);
  endtask

  // Present one instruction and hold it until the LSU takes it.
  task automatic send(input logic [63:0] pc, input logic [31:0] ins, input logic wen,
                      input logic [4:0] rd, input logic [63:0] alu, input logic [63:0] st,
                      input logic [4:0] op);
    int k = 0;
    PC5 = pc; Ins4 = ins; reg_w_en3 = wen; rdest2 = rd; ALU_res = alu; st_data = st; mem_op = op;
    valid5 = 1'b1;
    while (!ready5 && k < 50) begin tick(); k++; end
    if (k == 50) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: ready5 stayed %b, expected 1 within 50 cycles", ready5);
    end
    tick();
    valid5 = 1'b0;
  endtask

  task automatic serve(input int req_wait, input int rsp_wait, input logic [63:0] rd);
    repeat (req_wait) tick();
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    repeat (rsp_wait) tick();
    mem_rsp_valid = 1'b1; mem_rdata = rd; tick(); mem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({valid6, mem_req_valid, PC6, Ins5, reg_w_en4, rdest3, WB_data1, mem_addr, mem_wdata, mem_wmask, mem_wen} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got valid6=%b req=%b pc6=%h wb=%h addr=%h, expected all 0",
               valid6, mem_req_valid, PC6, WB_data1, mem_addr);
    end
    tick(); reset = 1'b1; #1;
    n_vec++;
    if (ready5 !== 1'b1) begin n_err++; $display("FAIL reset_ready5: got %b, expected 1", ready5); end
    mem_req_ready = 1'b0;
    send(64'h500, 32'h0000_3003, 1'b1, 5'd9, 64'h5008, 64'h0, 5'b10110);
    n_vec++;
    if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL reset_req_before: got %b, expected 1", mem_req_valid); end
    tick();
    reset = 1'b0; #1;
    n_vec++;
    if (mem_req_valid !== 1'b0 || valid6 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_midreq: got req=%b valid6=%b, expected 0 0", mem_req_valid, valid6);
    end
    #3 reset = 1'b1;
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 64'hFFFF; tick(); mem_rsp_valid = 1'b0;
    tick();
    n_vec++;
    if (valid6 !== 1'b0 || ready5 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_stale_rsp: got valid6=%b ready5=%b, expected 0 1", valid6, ready5);
    end
  endtask

  task automatic test_alu();
    ready6 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      expect_wb(64'h100 + 64'(4 * i), 32'h13 + 32'(i), 1'b1, 5'(i), 64'(i));
      send(64'h100 + 64'(4 * i), 32'h13 + 32'(i), 1'b1, 5'(i), 64'(i), 64'h0, 5'b00000);
      n_vec++;
      if (valid6 !== 1'b1 || WB_data1 !== 64'(i)) begin
        n_err++;
        $display("FAIL alu_b2b_%0d: got valid6=%b data=%h, expected 1 %h", i, valid6, WB_data1, 64'(i));
      end
    end
    tick();
  endtask

  task automatic test_load();
    ready6 = 1'b1;
    expect_wb(64'h200, 32'h0031_8003, 1'b1, 5'd5, 64'hFFFF_FFFF_FFFF_FF80);
    send(64'h200, 32'h0031_8003, 1'b1, 5'd5, 64'h1003, 64'h0, 5'b10000);
    n_vec++;
    if (mem_addr !== 64'h1000 || mem_wen !== 1'b0 || mem_req_valid !== 1'b1) begin
      n_err++;
      $display("FAIL lb_request: got addr=%h wen=%b req=%b, expected 1000 0 1", mem_addr, mem_wen, mem_req_valid);
    end
    serve(0, 0, 64'h0000_0000_8000_0000);
    n_vec++;
    if (valid6 !== 1'b1) begin n_err++; $display("FAIL lb_latency: got valid6=%b, expected 1", valid6); end
    tick();
    expect_wb(64'h204, 32'h0031_C003, 1'b1, 5'd6, 64'h80);
    send(64'h204, 32'h0031_C003, 1'b1, 5'd6, 64'h1003, 64'h0, 5'b10001);
    serve(0, 0, 64'h0000_0000_8000_0000);
    tick();
    expect_wb(64'h208, 32'h0031_A003, 1'b1, 5'd7, 64'hFFFF_FFFF_8765_4321);
    send(64'h208, 32'h0031_A003, 1'b1, 5'd7, 64'h1004, 64'h0, 5'b10100);
    serve(1, 2, 64'h8765_4321_0000_0000);
    tick();
  endtask

  task automatic test_store();
    ready6 = 1'b1;
    expect_wb(64'h300, 32'h00A0_1323, 1'b0, 5'd0, 64'h2006);
    send(64'h300, 32'h00A0_1323, 1'b0, 5'd0, 64'h2006, 64'hABCD, 5'b11010);
    n_vec++;
    if (mem_wdata !== 64'hABCD_0000_0000_0000 || mem_wmask !== 8'hC0 || mem_wen !== 1'b1 || mem_addr !== 64'h2000) begin
      n_err++;
      $display("FAIL sh_lanes: got wdata=%h mask=%h wen=%b addr=%h, expected abcd000000000000 c0 1 2000",
               mem_wdata, mem_wmask, mem_wen, mem_addr);
    end
    serve(0, 0, 64'h0);
    tick();
    expect_wb(64'h304, 32'h00A0_3223, 1'b0, 5'd0, 64'h3004);
    send(64'h304, 32'h00A0_3223, 1'b0, 5'd0, 64'h3004, 64'h1122_3344_5566_7788, 5'b11110);
    n_vec++;
    if (mem_wmask !== 8'hF0 || mem_wdata !== 64'h5566_7788_0000_0000) begin
      n_err++;
      $display("FAIL sd_off4: got mask=%h wdata=%h, expected f0 5566778800000000", mem_wmask, mem_wdata);
    end
    serve(0, 0, 64'h0);
    tick();
  endtask

  task automatic test_stall();
    ready6 = 1'b1;
    expect_wb(64'h400, 32'h00B0_2123, 1'b0, 5'd0, 64'h4002);
    send(64'h400, 32'h00B0_2123, 1'b0, 5'd0, 64'h4002, 64'hDEAD_BEEF, 5'b11100);
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if (mem_req_valid !== 1'b1 || mem_addr !== 64'h4000 || mem_wdata !== 64'h0000_DEAD_BEEF_0000 ||
          mem_wmask !== 8'h3C || mem_wen !== 1'b1) begin
        n_err++;
        $display("FAIL req_stall_c%0d: got req=%b addr=%h wdata=%h mask=%h, expected 1 4000 0000deadbeef0000 3c",
                 c, mem_req_valid, mem_addr, mem_wdata, mem_wmask);
      end
      tick();
    end
    mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      n_vec++;
      if (mem_req_valid !== 1'b0 || valid6 !== 1'b0) begin
        n_err++;
        $display("FAIL rsp_wait_c%0d: got req=%b valid6=%b, expected 0 0", c, mem_req_valid, valid6);
      end
      tick();
    end
    mem_rsp_valid = 1'b1; mem_rdata = 64'h5A5A; tick(); mem_rsp_valid = 1'b0;
    n_vec++;
    if (valid6 !== 1'b1) begin n_err++; $display("FAIL rsp_done: got valid6=%b, expected 1", valid6); end
    tick();
    n_vec++;
    if (valid6 !== 1'b0) begin n_err++; $display("FAIL rsp_single: got valid6=%b, expected 0", valid6); end
  endtask

  task automatic test_wb_stall();
    ready6 = 1'b0;
    expect_wb(64'h600, 32'h0000_3083, 1'b1, 5'd1, 64'h0123_4567_89AB_CDEF);
    send(64'h600, 32'h0000_3083, 1'b1, 5'd1, 64'h6000, 64'h0, 5'b10110);
    serve(0, 0, 64'h0123_4567_89AB_CDEF);
    expect_wb(64'h604, 32'h0770_0113, 1'b1, 5'd2, 64'h77);
    PC5 = 64'h604; Ins4 = 32'h0770_0113; reg_w_en3 = 1'b1; rdest2 = 5'd2;
    ALU_res = 64'h77; st_data = 64'h0; mem_op = 5'b00000; valid5 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (valid6 !== 1'b1 || WB_data1 !== 64'h0123_4567_89AB_CDEF || PC6 !== 64'h600 ||
          ready5 !== 1'b0 || mem_req_valid !== 1'b0) begin
        n_err++;
        $display("FAIL wb_hold_c%0d: got valid6=%b data=%h pc6=%h ready5=%b req=%b, expected 1 0123456789abcdef 600 0 0",
                 c, valid6, WB_data1, PC6, ready5, mem_req_valid);
      end
      tick();
    end
    ready6 = 1'b1; #1;
    n_vec++;
    if (ready5 !== 1'b1) begin n_err++; $display("FAIL wb_release_ready5: got %b, expected 1", ready5); end
    @(posedge clk); #1;
    valid5 = 1'b0;
    n_vec++;
    if (valid6 !== 1'b1 || WB_data1 !== 64'h77) begin
      n_err++;
      $display("FAIL wb_reload: got valid6=%b data=%h, expected 1 77", valid6, WB_data1);
    end
    tick();
  endtask

  task automatic test_spurious();
    ready6 = 1'b1;
    mem_rsp_valid = 1'b1; mem_rdata = 64'hBAD; tick(); mem_rsp_valid = 1'b0;
    tick();
    n_vec++;
    if (valid6 !== 1'b0 || mem_req_valid !== 1'b0 || ready5 !== 1'b1) begin
      n_err++;
      $display("FAIL spurious_rsp: got valid6=%b req=%b ready5=%b, expected 0 0 1", valid6, mem_req_valid, ready5);
    end
  endtask

  initial begin
    reset = 1'b0; valid5 = 1'b0; PC5 = '0; Ins4 = '0; reg_w_en3 = 1'b0; rdest2 = '0;
    ALU_res = '0; st_data = '0; mem_op = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    mem_rdata = '0; ready6 = 1'b1;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_stall();
    test_wb_stall();
    test_spurious();
    repeat (3) tick();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d results outstanding, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
